// File: rtl/spi_rx_ip.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_ip
// Brief    : Slave-side SPI receiver. It oversamples scl/sda/cs, assembles
//            MSB-first words and signals overrun through a pending/ack handshake.
// Revision : 1.0
// ============================================================================
module spi_rx_ip #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl,
    input  logic                  sda,
    input  logic                  cs,
    input  logic                  ack,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  pending,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int c_CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_live;
    logic                   r_scl_d;
    logic                   r_armed;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_bitcnt;
    logic [DATA_WIDTH-2:0]  r_shift;

    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_cs_s;
    logic                   w_rise;
    logic                   w_sample;
    logic                   w_done;
    logic [DATA_WIDTH-1:0]  w_word;

    assign w_scl_s  = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s  = r_sda_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_rise   = w_scl_s & ~r_scl_d;
    assign w_sample = (r_state == S_SHIFT) & ~w_cs_s & w_rise;
    assign w_done   = w_sample & (r_bitcnt == c_CNT_W'(DATA_WIDTH - 1));
    assign w_word   = {r_shift, w_sda_s};

    // r_live marks when the chains hold real pin values instead of reset fill,
    // so a cs that is already low at reset release cannot open a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_scl_sync <= '0;
            r_sda_sync <= '0;
            r_cs_sync  <= '1;
            r_live     <= '0;
            r_scl_d    <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_live     <= {r_live[SYNC_STAGES-2:0], 1'b1};
            r_scl_d    <= w_scl_s;
            r_armed    <= r_armed | (r_live[SYNC_STAGES-1] & w_cs_s);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_armed && !w_cs_s) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_cs_s)             w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bitcnt  <= '0;
            r_shift   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= w_done;
            overrun   <= w_done & pending & ~ack;
            frame_err <= (r_state == S_SHIFT) & w_cs_s & (r_bitcnt != '0);

            // Outside an active frame the word assembly is held cleared.
            if ((r_state != S_SHIFT) || w_cs_s) begin
                r_bitcnt <= '0;
                r_shift  <= '0;
            end else if (w_sample) begin
                r_bitcnt <= w_done ? '0 : r_bitcnt + 1'b1;
                r_shift  <= w_word[DATA_WIDTH-2:0];
            end

            if (w_done) begin
                data_out <= w_word;
            end

            if (w_done) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_ip.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rx_ip
// Brief    : Directed bench for spi_rx_ip with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_spi_rx_ip;

    logic       clk;
    logic       reset;
    logic       scl;
    logic       sda;
    logic       cs;
    logic       ack;
    logic [7:0] data_out;
    logic       valid;
    logic       pending;
    logic       overrun;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_ovr    = 0;
    int n_ovr_mis = 0;
    int n_ferr   = 0;
    int v0, o0, f0;

    spi_rx_ip #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .cs        (cs),
        .ack       (ack),
        .data_out  (data_out),
        .valid     (valid),
        .pending   (pending),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (overrun) begin
            n_ovr++;
            if (!valid) n_ovr_mis++;
        end
        if (frame_err) n_ferr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One scl period: 4 clks low, 4-5 clks high (meets the 3-clk minimum).
    task automatic send_bit(input logic b, input bit glitch, input bit ack_rise);
        sda = b;
        tick(4);
        scl = 1'b1;
        if (ack_rise) begin
            // ack lands in the sampling cycle: scl_s high, scl_s_d still low
            @(posedge clk);
            @(posedge clk);
            @(negedge clk);
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            tick(2);
        end else if (glitch) begin
            tick(2);
            sda = ~b;
            tick(2);
        end else begin
            tick(4);
        end
        scl = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit ack_last, input bit glitch);
        for (int i = 7; i >= 0; i--) send_bit(w[i], glitch, ack_last && (i == 0));
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        tick(1);
    endtask

    initial begin
        reset = 1'b0;
        scl   = 1'b0;
        sda   = 1'b0;
        cs    = 1'b1;
        ack   = 1'b0;
        #1;
        chk("reset_outputs", {data_out, valid, pending, overrun, frame_err}, 32'h0);
        tick(3);
        reset = 1'b1;
        tick(6);

        // T6a: scl activity with cs high is ignored
        v0 = n_valid;
        send_word(8'hFF, 1'b0, 1'b0);
        chk("t6_bitcnt_cs_high", 32'(dut.r_bitcnt), 32'h0);
        chk("t6_no_valid_cs_high", n_valid - v0, 0);

        // T1: basic frame
        v0 = n_valid;
        cs_low();
        send_word(8'hA5, 1'b0, 1'b0);
        cs_high();
        chk("t1_data", data_out, 8'hA5);
        chk("t1_valid_count", n_valid - v0, 1);
        chk("t1_pending_set", pending, 1'b1);
        pulse_ack();
        chk("t1_pending_clr", pending, 1'b0);

        // T2: back-to-back words, acked
        v0 = n_valid;
        o0 = n_ovr;
        cs_low();
        send_word(8'h3C, 1'b0, 1'b0);
        chk("t2_data_first", data_out, 8'h3C);
        pulse_ack();
        send_word(8'hC3, 1'b0, 1'b0);
        pulse_ack();
        cs_high();
        chk("t2_data_second", data_out, 8'hC3);
        chk("t2_valid_count", n_valid - v0, 2);
        chk("t2_no_overrun", n_ovr - o0, 0);
        chk("t2_pending", pending, 1'b0);

        // T3: overrun with no ack
        o0 = n_ovr;
        cs_low();
        send_word(8'h11, 1'b0, 1'b0);
        chk("t3_no_ovr_first", n_ovr - o0, 0);
        send_word(8'h22, 1'b0, 1'b0);
        cs_high();
        chk("t3_overrun_count", n_ovr - o0, 1);
        chk("t3_overrun_aligned", n_ovr_mis, 0);
        chk("t3_data", data_out, 8'h22);
        chk("t3_pending", pending, 1'b1);
        pulse_ack();

        // T3 variant: ack coincides with the second completion
        o0 = n_ovr;
        cs_low();
        send_word(8'h11, 1'b0, 1'b0);
        send_word(8'h22, 1'b1, 1'b0);
        cs_high();
        chk("t3v_no_overrun", n_ovr - o0, 0);
        chk("t3v_pending", pending, 1'b1);
        chk("t3v_data", data_out, 8'h22);
        pulse_ack();

        // T4: aborted frame after 5 bits
        v0 = n_valid;
        f0 = n_ferr;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        cs_high();
        chk("t4_frame_err", n_ferr - f0, 1);
        chk("t4_no_valid", n_valid - v0, 0);
        chk("t4_data_kept", data_out, 8'h22);
        cs_low();
        send_word(8'h0F, 1'b0, 1'b0);
        cs_high();
        chk("t4_data_next", data_out, 8'h0F);
        chk("t4_no_extra_ferr", n_ferr - f0, 1);

        // T5: reset mid-frame (pending left set from T4)
        cs_low();
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t5_async_clear", {data_out, valid, pending, overrun, frame_err}, 32'h0);
        tick(2);
        reset = 1'b1;
        v0 = n_valid;
        f0 = n_ferr;
        tick(4);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        cs_high();
        chk("t5_ignored_ferr", n_ferr - f0, 0);
        chk("t5_ignored_valid", n_valid - v0, 0);
        cs_low();
        send_word(8'h81, 1'b0, 1'b0);
        cs_high();
        chk("t5_data", data_out, 8'h81);
        chk("t5_valid_count", n_valid - v0, 1);

        // T6b: sda flips during scl high; the value at the rise is kept
        cs_low();
        send_word(8'h96, 1'b0, 1'b1);
        cs_high();
        chk("t6_glitch_data", data_out, 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
